// File: rtl/matmul_seq_pkg.sv
// Shared types for the matmul job sequencer: FSM state encoding and the queued job descriptor.
// Descriptor fields are sized for the widest supported configuration; unused upper bits stay zero.
package matmul_seq_pkg;

  localparam int MAX_DIM_BITS  = 16;
  localparam int MAX_ADDR_BITS = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RETIRE = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic [MAX_DIM_BITS-1:0]  m;
    logic [MAX_DIM_BITS-1:0]  n;
    logic [MAX_DIM_BITS-1:0]  k;
    logic [MAX_ADDR_BITS-1:0] addr_in1;
    logic [MAX_ADDR_BITS-1:0] addr_in2;
    logic [MAX_ADDR_BITS-1:0] addr_out;
  } job_desc_t;

  // A descriptor with any empty dimension cannot be run by the core.
  function automatic logic has_zero_dim(input job_desc_t d);
    return (d.m == '0) || (d.n == '0) || (d.k == '0);
  endfunction

endpackage

// File: rtl/job_fifo.sv
// Synchronous descriptor FIFO; full/empty are registered from the next occupancy.
// Pushes while full and pops while empty are dropped.
module job_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_next;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == CW'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/matmul_job_sequencer.sv
// Queues matmul job descriptors and launches them one at a time on the systolic core.
// Optional PERF_CNT_EN adds a cycle_count port reporting the WAIT length of the last job.
module matmul_job_sequencer
  import matmul_seq_pkg::*;
#(
  parameter int MAT_SIZE_BITS = 4,
  parameter int BRAM_DEPTH    = 10,
  parameter int JOB_DEPTH     = 4,
  parameter int TIMEOUT_BITS  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     job_valid,
  output logic                     job_ready,
  input  logic [MAT_SIZE_BITS-1:0] job_m,
  input  logic [MAT_SIZE_BITS-1:0] job_n,
  input  logic [MAT_SIZE_BITS-1:0] job_k,
  input  logic [BRAM_DEPTH-1:0]    job_addr_in1,
  input  logic [BRAM_DEPTH-1:0]    job_addr_in2,
  input  logic [BRAM_DEPTH-1:0]    job_addr_out,
  input  logic                     go,
  input  logic                     auto_run,
  output logic                     core_start,
  output logic [MAT_SIZE_BITS-1:0] core_m,
  output logic [MAT_SIZE_BITS-1:0] core_n,
  output logic [MAT_SIZE_BITS-1:0] core_k,
  output logic [BRAM_DEPTH-1:0]    core_addr_in1,
  output logic [BRAM_DEPTH-1:0]    core_addr_in2,
  output logic [BRAM_DEPTH-1:0]    core_addr_out,
  input  logic                     core_done,
  input  logic                     core_err,
  output logic                     busy,
  output logic [7:0]               jobs_done,
  output logic                     err_sticky,
  output logic                     timeout
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]              cycle_count
`endif
);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_LAUNCH = LAUNCH;
  localparam logic [1:0] ST_WAIT   = WAIT;
  localparam logic [1:0] ST_RETIRE = RETIRE;
  localparam int         CW        = $clog2(JOB_DEPTH) + 1;

  logic [1:0]              state;
  logic                    armed;
  logic [TIMEOUT_BITS-1:0] watchdog;
  logic [TIMEOUT_BITS-1:0] watchdog_inc;
  logic                    watchdog_expired;
  job_desc_t               push_desc;
  job_desc_t               head_desc;
  logic                    push_fire;
  logic                    pop_fire;
  logic                    full;
  logic                    empty;
  logic [CW-1:0]           occupancy;
  logic                    queue_drains;
  logic                    unused_desc;

  assign job_ready        = !full;
  assign push_fire        = job_valid && job_ready;
  assign pop_fire         = (state == ST_RETIRE);
  assign busy             = (state != ST_IDLE);
  assign watchdog_inc     = watchdog + 1'b1;
  assign watchdog_expired = (watchdog_inc == '1);
  assign queue_drains     = (occupancy == CW'(1)) && !push_fire;
  // Upper descriptor bits are always zero; fold them so nothing dangles.
  assign unused_desc      = ^head_desc;

  always_comb begin
    push_desc          = '0;
    push_desc.m        = MAX_DIM_BITS'(job_m);
    push_desc.n        = MAX_DIM_BITS'(job_n);
    push_desc.k        = MAX_DIM_BITS'(job_k);
    push_desc.addr_in1 = MAX_ADDR_BITS'(job_addr_in1);
    push_desc.addr_in2 = MAX_ADDR_BITS'(job_addr_in2);
    push_desc.addr_out = MAX_ADDR_BITS'(job_addr_out);
  end

  job_fifo #(
    .WIDTH ($bits(job_desc_t)),
    .DEPTH (JOB_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_fire),
    .wr_data (push_desc),
    .pop     (pop_fire),
    .rd_data (head_desc),
    .full    (full),
    .empty   (empty),
    .count   (occupancy)
  );

  // Armed is cleared only when the retiring job leaves the queue empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed <= 1'b0;
    end else if (state == ST_RETIRE && armed && queue_drains) begin
      armed <= 1'b0;
    end else if (go) begin
      armed <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      core_start    <= 1'b0;
      core_m        <= '0;
      core_n        <= '0;
      core_k        <= '0;
      core_addr_in1 <= '0;
      core_addr_in2 <= '0;
      core_addr_out <= '0;
      jobs_done     <= '0;
      err_sticky    <= 1'b0;
      timeout       <= 1'b0;
      watchdog      <= '0;
    end else begin
      core_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!empty && (auto_run || armed)) state <= ST_LAUNCH;
        end
        ST_LAUNCH: begin
          core_m        <= head_desc.m[MAT_SIZE_BITS-1:0];
          core_n        <= head_desc.n[MAT_SIZE_BITS-1:0];
          core_k        <= head_desc.k[MAT_SIZE_BITS-1:0];
          core_addr_in1 <= head_desc.addr_in1[BRAM_DEPTH-1:0];
          core_addr_in2 <= head_desc.addr_in2[BRAM_DEPTH-1:0];
          core_addr_out <= head_desc.addr_out[BRAM_DEPTH-1:0];
          watchdog      <= '0;
          if (has_zero_dim(head_desc)) begin
            err_sticky <= 1'b1;
            state      <= ST_RETIRE;
          end else begin
            core_start <= 1'b1;
            state      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          watchdog <= watchdog_inc;
          // A completion landing on the expiry cycle wins over the watchdog.
          if (core_done) begin
            if (core_err) err_sticky <= 1'b1;
            state <= ST_RETIRE;
          end else if (watchdog_expired) begin
            timeout    <= 1'b1;
            err_sticky <= 1'b1;
            state      <= ST_RETIRE;
          end
        end
        ST_RETIRE: begin
          jobs_done <= jobs_done + 8'd1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef PERF_CNT_EN
  logic [31:0] perf_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cnt    <= '0;
      cycle_count <= '0;
    end else begin
      case (state)
        ST_LAUNCH: perf_cnt <= '0;
        ST_WAIT:   if (perf_cnt != '1) perf_cnt <= perf_cnt + 32'd1;
        ST_RETIRE: cycle_count <= perf_cnt;
        default:   perf_cnt <= perf_cnt;
      endcase
    end
  end
`endif

endmodule

// File: doc/matmul_job_sequencer.md
MATMUL_JOB_SEQUENCER -- requirements
Module: matmul_job_sequencer

Interface
REQ-001 SHALL have parameter MAT_SIZE_BITS, default 4, width of the M/N/K dimension fields.
REQ-002 SHALL have parameter BRAM_DEPTH, default 10, width of the BRAM base-address fields.
REQ-003 SHALL have parameter JOB_DEPTH, default 4, job queue entries; must be a power of 2 and at least 2.
REQ-004 SHALL have parameter TIMEOUT_BITS, default 16, width of the per-job watchdog.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 Ports (name, direction, width, meaning):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- job_valid  in  1  descriptor push request.
- job_ready  out  1  queue can accept a push.
- job_m, job_n, job_k  in  MAT_SIZE_BITS  each: descriptor dimensions.
- job_addr_in1, job_addr_in2, job_addr_out  in  BRAM_DEPTH  each: descriptor base addresses.
- go  in  1  single-cycle pulse, already debounced; arms the block to drain the queue.
- auto_run  in  1  launch whenever the queue is non-empty.
- core_start  out  1  single-cycle start to the systolic core.
- core_m, core_n, core_k  out  MAT_SIZE_BITS  each: active job dimensions.
- core_addr_in1, core_addr_in2, core_addr_out  out  BRAM_DEPTH  each: active job base addresses.
- core_done  in  1  core completion pulse.
- core_err  in  1  core error, sampled with core_done.
- busy  out  1  state is not IDLE.
- jobs_done  out  8  retired-job count, wraps modulo 256.
- err_sticky  out  1  latched error.
- timeout  out  1  latched watchdog expiry.
- cycle_count  out  32  cycles of the last job; present only under PERF_CNT_EN.

Function
REQ-007 A push SHALL occur when job_valid and job_ready are both high; job_ready = !full, and job_ready SHALL stay low while full, including on a pop cycle.
REQ-008 A push and a pop in the same cycle SHALL both take effect, leaving the occupancy unchanged; read and write pointers wrap modulo JOB_DEPTH.
REQ-009 The FSM SHALL have the states IDLE, LAUNCH, WAIT, RETIRE.
REQ-010 IDLE->LAUNCH SHALL occur when the queue is non-empty and (auto_run or armed).
REQ-011 armed SHALL be set by go and cleared in RETIRE when the queue becomes empty.
REQ-012 go while already armed SHALL have no effect.
REQ-013 go with an empty queue SHALL set armed; the next push then launches.
REQ-014 LAUNCH SHALL register the head descriptor onto the core_* outputs and pulse core_start for exactly one cycle, then go to WAIT.
REQ-015 The core_* descriptor outputs SHALL stay stable until the next LAUNCH.
REQ-016 A head descriptor with M, N or K equal to 0 SHALL NOT pulse core_start; LAUNCH goes directly to RETIRE and sets err_sticky.
REQ-017 WAIT->RETIRE SHALL occur on core_done; core_err=1 at that cycle sets err_sticky.
REQ-018 WAIT SHALL increment a watchdog counter each cycle.
REQ-019 At watchdog value 2^TIMEOUT_BITS-1 the FSM SHALL go to RETIRE and set timeout and err_sticky.
REQ-020 core_done arriving in the same cycle as watchdog expiry SHALL take precedence: no timeout is flagged.
REQ-021 RETIRE SHALL pop the head and increment jobs_done, then go to IDLE; the minimum job-to-job spacing is 4 cycles.
REQ-022 core_done outside WAIT SHALL be ignored.
REQ-023 err_sticky and timeout SHALL clear only on rst.

Reset
REQ-024 On rst, all of the following SHALL be 0: queue pointers and occupancy, armed, state (IDLE), core_start, core_* descriptor outputs, busy, jobs_done, err_sticky, timeout, watchdog, cycle_count.
REQ-025 rst during WAIT SHALL abandon the job with no core_start re-issue; queued jobs are lost.

Configuration
REQ-026 With PERF_CNT_EN defined, a 32-bit counter SHALL clear in LAUNCH, increment each WAIT cycle, saturate at all-ones, and load cycle_count in RETIRE.
REQ-027 With PERF_CNT_EN undefined, the cycle_count port and counter SHALL be absent; all other behaviour is identical.

Structure
REQ-028 Package matmul_seq_pkg SHALL hold the state enum and the job descriptor packed struct (m, n, k, addr_in1, addr_in2, addr_out).
REQ-029 The queue SHALL be sub-module job_fifo (parametrised width and depth, synchronous, registered full/empty).

Verification
REQ-030 Push 3 valid jobs, pulse go, core_done 10 cycles after each core_start -> 3 core_start pulses with matching descriptors, jobs_done=3, armed clears, busy low.
REQ-031 JOB_DEPTH=4: push 5 jobs with job_valid held -> job_ready low after the 4th; simultaneous push and pop while at 3 entries keeps occupancy at 3.
REQ-032 Job M=0 queued, auto_run=1 -> no core_start, err_sticky=1, jobs_done increments.
REQ-033 TIMEOUT_BITS=4, core_done never asserted -> timeout=1 after 15 WAIT cycles; core_done at cycle 15 -> no timeout.
REQ-034 core_err=1 with core_done -> err_sticky=1; cycle_count equals the WAIT length under PERF_CNT_EN.
REQ-035 rst asserted in WAIT -> next cycle all outputs 0, the queue empty, and no core_start.
